// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mc
//  Description : Multi-cycle integer ALU for the execute stage. Single-cycle
//                logic/arith/shift/compare ops plus iterative unsigned
//                multiply (shift-add) and divide (restoring), all behind a
//                valid/ready handshake on both the operand and result sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUcontrol_In,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             busy
);

  // Shift amount width: enough bits to address every bit of an operand.
  localparam int c_sh_w = CNT_W - 1;

  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  localparam logic [3:0] c_op_add   = 4'b0000;
  localparam logic [3:0] c_op_sub   = 4'b0001;
  localparam logic [3:0] c_op_and   = 4'b0010;
  localparam logic [3:0] c_op_or    = 4'b0011;
  localparam logic [3:0] c_op_xor   = 4'b0100;
  localparam logic [3:0] c_op_sll   = 4'b0101;
  localparam logic [3:0] c_op_srl   = 4'b0110;
  localparam logic [3:0] c_op_sra   = 4'b0111;
  localparam logic [3:0] c_op_slt   = 4'b1000;
  localparam logic [3:0] c_op_sltu  = 4'b1001;
  localparam logic [3:0] c_op_mul   = 4'b1010;
  localparam logic [3:0] c_op_mulhu = 4'b1011;
  localparam logic [3:0] c_op_divu  = 4'b1100;
  localparam logic [3:0] c_op_remu  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched operation for the iterative path. r_q starts as operand A and
  // ends as the product low half / quotient; r_acc starts at zero and ends
  // as the product high half / remainder.
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  logic             w_accept;
  logic             w_in_slow;
  logic [c_sh_w-1:0] w_shamt;
  logic [WIDTH-1:0] w_fast_result;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_acc_nxt;
  logic [WIDTH-1:0] w_mul_q_nxt;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_diff;
  logic [WIDTH-1:0] w_div_rem_nxt;
  logic [WIDTH-1:0] w_div_quo_nxt;
  logic             w_op_is_mul;
  logic [WIDTH-1:0] w_step_acc;
  logic [WIDTH-1:0] w_step_q;
  logic [WIDTH-1:0] w_slow_result;

  assign w_accept = in_valid && in_ready;
  assign w_shamt  = B[c_sh_w-1:0];

  // Classify the incoming opcode: multiply/divide family goes iterative.
  always_comb begin
    w_in_slow = 1'b0;
    case (ALUcontrol_In)
      c_op_mul, c_op_mulhu, c_op_divu, c_op_remu: w_in_slow = 1'b1;
      default:                                    w_in_slow = 1'b0;
    endcase
  end

  // Single-cycle result straight from the input operands.
  always_comb begin
    w_fast_result = '0;
    case (ALUcontrol_In)
      c_op_add:  w_fast_result = A + B;
      c_op_sub:  w_fast_result = A - B;
      c_op_and:  w_fast_result = A & B;
      c_op_or:   w_fast_result = A | B;
      c_op_xor:  w_fast_result = A ^ B;
      c_op_sll:  w_fast_result = A << w_shamt;
      c_op_srl:  w_fast_result = A >> w_shamt;
      c_op_sra:  w_fast_result = $signed(A) >>> w_shamt;
      c_op_slt:  w_fast_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      c_op_sltu: w_fast_result = {{(WIDTH-1){1'b0}}, (A < B)};
      default:   w_fast_result = '0;
    endcase
  end

  // One iteration of shift-add multiply and restoring divide. Both are
  // computed every cycle; the latched opcode picks which one is kept.
  always_comb begin
    w_mul_sum     = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    w_mul_acc_nxt = w_mul_sum[WIDTH:1];
    w_mul_q_nxt   = {w_mul_sum[0], r_q[WIDTH-1:1]};

    // Partial remainder can reach WIDTH+1 bits after the shift, so the
    // compare is done at that width. A zero divisor always "fits", which
    // yields an all-ones quotient and leaves A in the remainder.
    w_div_shift   = {r_acc, r_q[WIDTH-1]};
    w_div_ge      = (w_div_shift >= {1'b0, r_b});
    w_div_diff    = w_div_shift[WIDTH-1:0] - r_b;
    w_div_rem_nxt = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
    w_div_quo_nxt = {r_q[WIDTH-2:0], w_div_ge};

    w_op_is_mul   = (r_op == c_op_mul) || (r_op == c_op_mulhu);
    w_step_acc    = w_op_is_mul ? w_mul_acc_nxt : w_div_rem_nxt;
    w_step_q      = w_op_is_mul ? w_mul_q_nxt   : w_div_quo_nxt;

    w_slow_result = '0;
    case (r_op)
      c_op_mul:   w_slow_result = w_mul_q_nxt;
      c_op_mulhu: w_slow_result = w_mul_acc_nxt;
      c_op_divu:  w_slow_result = w_div_quo_nxt;
      c_op_remu:  w_slow_result = w_div_rem_nxt;
      default:    w_slow_result = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs. in_ready in DONE depends on out_ready
  // so a result can be consumed and a new op accepted on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = w_in_slow ? S_BUSY : S_DONE;
        end
      end
      S_BUSY: begin
        busy = 1'b1;
        if (r_cnt == c_cnt_one) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_state_nxt = w_in_slow ? S_BUSY : S_DONE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: latch operands on acceptance, iterate while BUSY, and write
  // Result/Zero together so they can never disagree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_cnt    <= '0;
      r_op     <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_q      <= '0;
    end else if (w_accept) begin
      if (w_in_slow) begin
        r_op  <= ALUcontrol_In;
        r_b   <= B;
        r_q   <= A;
        r_acc <= '0;
        r_cnt <= c_cnt_load;
      end else begin
        r_result <= w_fast_result;
        r_zero   <= (w_fast_result == '0);
      end
    end else if (r_state == S_BUSY) begin
      r_acc <= w_step_acc;
      r_q   <= w_step_q;
      r_cnt <= r_cnt - c_cnt_one;
      if (r_cnt == c_cnt_one) begin
        r_result <= w_slow_result;
        r_zero   <= (w_slow_result == '0);
      end
    end
  end

  assign Result = r_result;
  assign Zero   = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mc
//  Description : Self-checking bench for alu_mc: directed cases, a
//                back-to-back stream, reset during a multiply, and random
//                operations compared against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [3:0]   op_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .A             (a_in),
    .B             (b_in),
    .ALUcontrol_In (op_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .Result        (result),
    .Zero          (zero),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: results from plain integer arithmetic on wide values.
  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    logic [2*W-1:0] ext;
    int unsigned    sh;
    sh   = b % W;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    ext  = {{W{a[W-1]}}, a};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  begin ext = ext >> sh; return ext[W-1:0]; end
      4'd8:  return (int'(a) < int'(b)) ? 1 : 0;
      4'd9:  return (a < b) ? 1 : 0;
      4'd10: return prod[W-1:0];
      4'd11: return prod[2*W-1:W];
      4'd12: return (b == 0) ? {W{1'b1}} : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  // Issue one operation from IDLE, check latency, busy, result, then hold
  // the result for 'hold' cycles of backpressure before consuming it.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_r, input int hold);
    int  edges;
    int  busy_cnt;
    int  ir_cnt;
    bit  slow;
    slow = (op >= 4'd10) && (op <= 4'd13);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    op_in     = op;
    check($sformatf("in_ready_idle op%0d", op), 32'(in_ready), 32'd1);
    step();
    // Scramble inputs: the DUT must have latched them.
    in_valid = 1'b0;
    a_in     = $urandom;
    b_in     = $urandom;
    op_in    = 4'($urandom);
    edges = 0; busy_cnt = 0; ir_cnt = 0;
    while (!out_valid && edges < 40) begin
      busy_cnt += int'(busy);
      ir_cnt   += int'(in_ready);
      step();
      edges++;
    end
    check($sformatf("out_valid op%0d", op), 32'(out_valid), 32'd1);
    check($sformatf("latency op%0d", op), 32'(edges), slow ? 32'(W) : 32'd0);
    check($sformatf("busy_cycles op%0d", op), 32'(busy_cnt), slow ? 32'(W) : 32'd0);
    check($sformatf("in_ready_wait op%0d", op), 32'(ir_cnt), 32'd0);
    check($sformatf("result op%0d a=%h b=%h", op, a, b), result, exp_r);
    check($sformatf("zero op%0d", op), 32'(zero), 32'(exp_r == '0));
    for (int i = 0; i < hold; i++) begin
      step();
      check("hold_result", result, exp_r);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("in_ready_done", 32'(in_ready), 32'd1);
    step();
    out_ready = 1'b0;
    check("consumed", 32'(out_valid), 32'd0);
  endtask

  logic [3:0]   ops [8];
  logic [W-1:0] as  [8];
  logic [W-1:0] bs  [8];

  initial begin
    int ov_cnt;
    logic [3:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // Reset state.
    repeat (3) step();
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream: ADD wrap, SUB 5-7, then random single-cycle ops.
    ops[0] = 4'd0; as[0] = 32'hFFFF_FFFF; bs[0] = 32'd1;
    ops[1] = 4'd1; as[1] = 32'd5;         bs[1] = 32'd7;
    for (int i = 2; i < 8; i++) begin
      rop = 4'($urandom_range(0, 11));
      if (rop >= 4'd10) rop = rop + 4'd4;
      ops[i] = rop; as[i] = $urandom; bs[i] = $urandom;
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op_in = ops[0]; a_in = as[0]; b_in = bs[0];
    step();
    check("b2b_add_result", result, 32'd0);
    check("b2b_add_zero", 32'(zero), 32'd1);
    for (int i = 1; i < 8; i++) begin
      check($sformatf("b2b_valid %0d", i - 1), 32'(out_valid), 32'd1);
      check($sformatf("b2b_result %0d", i - 1), result, ref_alu(ops[i-1], as[i-1], bs[i-1]));
      check($sformatf("b2b_in_ready %0d", i), 32'(in_ready), 32'd1);
      op_in = ops[i]; a_in = as[i]; b_in = bs[i];
      step();
      if (i == 1) begin
        check("b2b_sub_result", result, 32'hFFFF_FFFE);
        check("b2b_sub_zero", 32'(zero), 32'd0);
      end
    end
    check("b2b_last", result, ref_alu(ops[7], as[7], bs[7]));
    in_valid = 1'b0;
    step();
    check("b2b_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Directed cases with hand-computed results.
    run_op(4'd7,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 0);
    run_op(4'd8,  32'hFFFF_FFFF, 32'd1,         32'd1,         0);
    run_op(4'd9,  32'hFFFF_FFFF, 32'd1,         32'd0,         0);
    run_op(4'd10, 32'h0001_0000, 32'h0001_0000, 32'd0,         0);
    run_op(4'd11, 32'h0001_0000, 32'h0001_0000, 32'd1,         0);
    run_op(4'd12, 32'd100,       32'd7,         32'd14,        10);
    run_op(4'd13, 32'd100,       32'd7,         32'd2,         0);
    run_op(4'd12, 32'd5,         32'd0,         32'hFFFF_FFFF, 0);
    run_op(4'd13, 32'd5,         32'd0,         32'd5,         0);
    run_op(4'd14, 32'd9,         32'd9,         32'd0,         1);

    // Reset in the middle of a multiply.
    in_valid = 1'b1; op_in = 4'd10; a_in = 32'h0001_0000; b_in = 32'h0001_0000;
    step();
    in_valid = 1'b0;
    repeat (15) step();
    check("mid_mul_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_zero", 32'(zero), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst_n = 1'b1;
    ov_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      ov_cnt += int'(out_valid);
    end
    out_ready = 1'b0;
    check("no_stale_result", 32'(ov_cnt), 32'd0);
    run_op(4'd0, 32'd2, 32'd3, 32'd5, 0);

    // Random operations against the reference model.
    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 40));
        default: rb = $urandom;
      endcase
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      run_op(rop, ra, rb, ref_alu(rop, ra, rb), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
